// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, grant encoding and writeback payload for the register-file
// writeback arbiter and its pending-write scoreboard.
package rf_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned CNT_W    = 2;

  localparam logic [ADDR_W-1:0] ILLEGAL_DEST = 4'd15;

  typedef enum logic {
    GNT_R0 = 1'b0,
    GNT_R1 = 1'b1
  } grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic dest_legal(input logic [ADDR_W-1:0] dest);
    return dest != ILLEGAL_DEST;
  endfunction

endpackage

// File: rtl/rf_pending_scoreboard.sv
// Per-register outstanding-write counters: issue increments, landed register
// file write decrements; exposes the busy vector and the saturation stall.
module rf_pending_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  output logic                issue_stall_c,
  output logic [NUM_REGS-1:0] busy_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_c;
  logic [NUM_REGS-1:0] dec_c;

  // Decrement for the register whose write lands this cycle.
  always_comb begin
    dec_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec_c[i] = wb_valid && (wb_dest == ADDR_W'(i));
    end
  end

  // A saturated counter only refuses an issue if no write is retiring it now.
  always_comb begin
    issue_stall_c = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issue_valid && (issue_dest == ADDR_W'(i)) &&
          (cnt_q[i] == CNT_MAX) && !dec_c[i]) begin
        issue_stall_c = 1'b1;
      end
    end
  end

  always_comb begin
    inc_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_c[i] = issue_valid && !issue_stall_c && (issue_dest == ADDR_W'(i));
    end
  end

  // Counters saturate at both ends; a stray decrement at zero is ignored.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case ({inc_c[i], dec_c[i]})
        2'b10: if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01: if (cnt_q[i] != '0)      cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_c[i] = (cnt_q[i] != '0);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// (r0) and load (r1) writeback paths, with a registered write port output.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_valid,
  input  logic [ADDR_W-1:0]   r0_dest,
  input  logic [DATA_W-1:0]   r0_data,
  output logic                r0_ready,
  input  logic                r1_valid,
  input  logic [ADDR_W-1:0]   r1_dest,
  input  logic [DATA_W-1:0]   r1_data,
  output logic                r1_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_stall,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_dest,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                err_dest
);

  grant_e  last_grant_q, last_grant_d;
  wb_req_t wb_q, wb_d;
  logic    rf_we_q, rf_we_d;
  logic    err_dest_q, err_dest_d;
  wb_req_t win_req_c;
  logic    accept_c;

  // Under contention the requester that did not win last time is granted.
  always_comb begin
    r0_ready = r0_valid && (!r1_valid || (last_grant_q == GNT_R1));
    r1_ready = r1_valid && (!r0_valid || (last_grant_q == GNT_R0));
    accept_c = r0_ready || r1_ready;
  end

  always_comb begin
    win_req_c = '0;
    if (r0_ready) begin
      win_req_c.dest = r0_dest;
      win_req_c.data = r0_data;
    end else if (r1_ready) begin
      win_req_c.dest = r1_dest;
      win_req_c.data = r1_data;
    end
  end

  // Illegal destinations are still consumed but only raise err_dest.
  always_comb begin
    rf_we_d      = 1'b0;
    err_dest_d   = 1'b0;
    wb_d         = wb_q;
    last_grant_d = last_grant_q;
    if (accept_c) begin
      wb_d         = win_req_c;
      rf_we_d      = dest_legal(win_req_c.dest);
      err_dest_d   = !dest_legal(win_req_c.dest);
      last_grant_d = r0_ready ? GNT_R0 : GNT_R1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_R1;
      wb_q         <= '0;
      rf_we_q      <= 1'b0;
      err_dest_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_q         <= wb_d;
      rf_we_q      <= rf_we_d;
      err_dest_q   <= err_dest_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_dest  = wb_q.dest;
  assign rf_data  = wb_q.data;
  assign err_dest = err_dest_q;

  rf_pending_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_dest    (issue_dest),
    .wb_valid      (rf_we_q),
    .wb_dest       (wb_q.dest),
    .issue_stall_c (issue_stall),
    .busy_c        (busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: writes expected by the stimulus are queued
// and a negedge monitor checks every register-file write or err_dest pulse.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic                clk;
  logic                rst;
  logic                r0_valid, r1_valid, issue_valid;
  logic [ADDR_W-1:0]   r0_dest, r1_dest, issue_dest;
  logic [DATA_W-1:0]   r0_data, r1_data;
  logic                r0_ready, r1_ready, issue_stall;
  logic                rf_we, err_dest;
  logic [ADDR_W-1:0]   rf_dest;
  logic [DATA_W-1:0]   rf_data;
  logic [NUM_REGS-1:0] busy;

  typedef struct {
    logic              err;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] rf_model [16];
  int                n_pass  = 0;
  int                n_total = 0;

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .r0_valid    (r0_valid),
    .r0_dest     (r0_dest),
    .r0_data     (r0_data),
    .r0_ready    (r0_ready),
    .r1_valid    (r1_valid),
    .r1_dest     (r1_dest),
    .r1_data     (r1_data),
    .r1_ready    (r1_ready),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_stall (issue_stall),
    .rf_we       (rf_we),
    .rf_dest     (rf_dest),
    .rf_data     (rf_data),
    .busy        (busy),
    .err_dest    (err_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic err, input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data);
    exp_t e;
    e.err  = err;
    e.dest = dest;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor plus register file model, which captures on the negedge.
  always @(negedge clk) begin
    if (!rst && (rf_we || err_dest)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: we=%0b err=%0b dest=%0d data=%0h, none expected",
                 rf_we, err_dest, rf_dest, rf_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_out", 64'({err_dest, rf_we, rf_dest, rf_data}),
              64'({e.err, !e.err, e.dest, e.data}));
      end
    end
    if (rf_we) rf_model[rf_dest] = rf_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    rst = 1'b1;
    r0_valid = 0; r0_dest = '0; r0_data = '0;
    r1_valid = 0; r1_dest = '0; r1_data = '0;
    issue_valid = 0; issue_dest = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err_dest), 64'd0);
    check("reset_rf_dest", 64'(rf_dest), 64'd0);
    rst = 1'b0;

    // Contention: r0 wins the first tie, then strict alternation.
    r0_valid = 1; r0_dest = 4'd1; r0_data = 32'hA0A0_0001;
    r1_valid = 1; r1_dest = 4'd2; r1_data = 32'hB0B0_0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_r0_ready", 64'(r0_ready), 64'(k % 2 == 0));
      check("cont_r1_ready", 64'(r1_ready), 64'(k % 2 == 1));
      if (k % 2 == 0) push(1'b0, 4'd1, 32'hA0A0_0001);
      else            push(1'b0, 4'd2, 32'hB0B0_0002);
      tick();
    end
    r0_valid = 0; r1_valid = 0;
    check("cont_4th_we", 64'(rf_we), 64'd1);
    tick();
    check("cont_we_done", 64'(rf_we), 64'd0);
    check("cont_busy_no_wrap", 64'(busy), 64'd0);

    // Single requester: one-cycle write, register file holds it afterwards.
    r0_valid = 1; r0_dest = 4'd3; r0_data = 32'hDEAD_BEEF;
    #1;
    check("single_ready", 64'(r0_ready), 64'd1);
    push(1'b0, 4'd3, 32'hDEAD_BEEF);
    tick();
    r0_valid = 0;
    check("single_we_n1", 64'(rf_we), 64'd1);
    tick();
    check("single_we_n2", 64'(rf_we), 64'd0);
    check("single_dest_hold", 64'(rf_dest), 64'd3);
    check("single_rf_r3", 64'(rf_model[3]), 64'hDEAD_BEEF);

    // Scoreboard: fill register 5 to saturation.
    issue_valid = 1; issue_dest = 4'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sb_issue_nostall", 64'(issue_stall), 64'd0);
      tick();
    end
    #1;
    check("sb_busy5", 64'(busy), 64'h0020);
    check("sb_stall_full", 64'(issue_stall), 64'd1);
    tick();
    issue_valid = 0;
    r0_valid = 1; r0_dest = 4'd5; r0_data = 32'h0000_0055;
    push(1'b0, 4'd5, 32'h0000_0055);
    tick();
    r0_valid = 0;
    issue_valid = 1; issue_dest = 4'd5;
    #1;
    check("sb_stall_drop", 64'(issue_stall), 64'd0);
    check("sb_we_5", 64'(rf_we), 64'd1);
    tick();
    #1;
    check("sb_same_cycle_net", 64'(issue_stall), 64'd1);
    issue_valid = 0;
    r0_valid = 1; r0_data = 32'h0000_0051;
    push(1'b0, 4'd5, 32'h0000_0051);
    tick();
    r0_data = 32'h0000_0052;
    push(1'b0, 4'd5, 32'h0000_0052);
    tick();
    r0_data = 32'h0000_0053;
    push(1'b0, 4'd5, 32'h0000_0053);
    tick();
    r0_valid = 0;
    check("sb_busy5_one_left", 64'(busy), 64'h0020);
    tick();
    check("sb_busy5_clear", 64'(busy), 64'd0);

    // Illegal destination: accepted, no write, err pulse only.
    r1_valid = 1; r1_dest = 4'd15; r1_data = 32'h0000_1234;
    #1;
    check("ill_r1_ready", 64'(r1_ready), 64'd1);
    check("ill_r0_ready", 64'(r0_ready), 64'd0);
    push(1'b1, 4'd15, 32'h0000_1234);
    tick();
    r1_valid = 0;
    check("ill_err_pulse", 64'(err_dest), 64'd1);
    check("ill_no_we", 64'(rf_we), 64'd0);
    tick();
    check("ill_err_done", 64'(err_dest), 64'd0);
    check("ill_busy", 64'(busy), 64'd0);

    issue_valid = 1; issue_dest = 4'd15;
    #1;
    check("issue15_nostall", 64'(issue_stall), 64'd0);
    tick();
    issue_valid = 0;
    check("issue15_busy", 64'(busy), 64'd0);

    // Reset while a write to 7 is pending and r0 is granted.
    issue_valid = 1; issue_dest = 4'd7;
    tick();
    issue_valid = 0;
    check("rst_busy7", 64'(busy), 64'h0080);
    r0_valid = 1; r0_dest = 4'd7; r0_data = 32'h0000_0077;
    #1;
    check("rst_r0_ready", 64'(r0_ready), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_we", 64'(rf_we), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_err", 64'(err_dest), 64'd0);
    r0_valid = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_after_we", 64'(rf_we), 64'd0);
    check("rst_after_busy", 64'(busy), 64'd0);

    // First tie after reset goes to r0.
    r0_valid = 1; r0_dest = 4'd1; r0_data = 32'h0000_00C1;
    r1_valid = 1; r1_dest = 4'd2; r1_data = 32'h0000_00C2;
    #1;
    check("tie_r0_ready", 64'(r0_ready), 64'd1);
    check("tie_r1_ready", 64'(r1_ready), 64'd0);
    push(1'b0, 4'd1, 32'h0000_00C1);
    tick();
    r0_valid = 0; r1_valid = 0;
    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
